// File: rtl/exec_cdb_arb.sv
// exec_cdb_arb: collects results from NUM_FU functional-unit lanes into
// per-lane in-order FIFOs and drains up to NUM_CDB lane heads per cycle onto
// the common data bus ports using a round-robin scan starting at rr_ptr.
// Optional build macro: EXEC_CDB_BYPASS_EN lets an incoming result on an
// empty lane compete for a CDB port in the same cycle it arrives.
module exec_cdb_arb #(
  parameter int NUM_FU        = 3,
  parameter int NUM_CDB       = 1,
  parameter int FIFO_DEPTH    = 2,
  parameter int ROB_IDX_BITS  = 6,
  parameter int PHYS_REG_BITS = 6,
  parameter int ARCH_REG_BITS = 5,
  parameter int DATA_W        = 32,
  localparam int LANE_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_FU-1:0]                 fu_valid,
  output logic [NUM_FU-1:0]                 fu_ready,
  input  logic [NUM_FU*ROB_IDX_BITS-1:0]    fu_rob_idx,
  input  logic [NUM_FU*PHYS_REG_BITS-1:0]   fu_pd,
  input  logic [NUM_FU*ARCH_REG_BITS-1:0]   fu_rd,
  input  logic [NUM_FU*DATA_W-1:0]          fu_rd_v,
  output logic [NUM_CDB-1:0]                cdb_valid,
  output logic [NUM_CDB*ROB_IDX_BITS-1:0]   cdb_rob_idx,
  output logic [NUM_CDB*PHYS_REG_BITS-1:0]  cdb_pd,
  output logic [NUM_CDB*ARCH_REG_BITS-1:0]  cdb_rd,
  output logic [NUM_CDB*DATA_W-1:0]         cdb_rd_v,
  output logic [NUM_CDB*LANE_W-1:0]         cdb_lane
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_IDX_BITS + PHYS_REG_BITS + ARCH_REG_BITS + DATA_W;
  // Field offsets inside a packed entry {rob_idx, pd, rd, rd_v}
  localparam int RD_V_LO = 0;
  localparam int RD_LO   = DATA_W;
  localparam int PD_LO   = DATA_W + ARCH_REG_BITS;
  localparam int ROB_LO  = DATA_W + ARCH_REG_BITS + PHYS_REG_BITS;

  logic [ENT_W-1:0]  lane_in   [NUM_FU];
  logic [ENT_W-1:0]  lane_head [NUM_FU];
  logic [NUM_FU-1:0] lane_req;
  logic [NUM_FU-1:0] lane_grant;
  logic [NUM_FU-1:0] lane_bypass;
  logic [LANE_W-1:0] rr_ptr_reg;
  logic [LANE_W-1:0] rr_ptr_next;
  logic [LANE_W-1:0] last_lane;
  int                arb_idx;
  int                arb_k;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_lane
      logic [ENT_W-1:0] mem_reg [FIFO_DEPTH];
      logic [PTR_W-1:0] head_reg;
      logic [PTR_W-1:0] tail_reg;
      logic [CNT_W-1:0] count_reg;
      logic             lane_empty;
      logic             do_enq;
      logic             do_deq;

      assign lane_in[gi] = {fu_rob_idx[gi*ROB_IDX_BITS +: ROB_IDX_BITS],
                            fu_pd[gi*PHYS_REG_BITS +: PHYS_REG_BITS],
                            fu_rd[gi*ARCH_REG_BITS +: ARCH_REG_BITS],
                            fu_rd_v[gi*DATA_W +: DATA_W]};
      assign lane_empty   = (count_reg == '0);
      // Ready uses only the registered count; a dequeue this cycle frees space next cycle.
      assign fu_ready[gi] = !rst && (count_reg < CNT_W'(FIFO_DEPTH));
`ifdef EXEC_CDB_BYPASS_EN
      assign lane_bypass[gi] = lane_empty && fu_valid[gi] && !flush && !rst;
`else
      assign lane_bypass[gi] = 1'b0;
`endif
      assign lane_req[gi]  = !rst && (!lane_empty || lane_bypass[gi]);
      assign lane_head[gi] = lane_empty ? lane_in[gi] : mem_reg[head_reg];
      // A bypassed result that wins a port is consumed directly and never stored.
      assign do_enq = fu_valid[gi] && fu_ready[gi] && !flush &&
                      !(lane_bypass[gi] && lane_grant[gi]);
      assign do_deq = lane_grant[gi] && !lane_empty;

      // Result storage: write at the tail on enqueue
      always_ff @(posedge clk) begin
        if (do_enq) mem_reg[tail_reg] <= lane_in[gi];
      end

      // Lane occupancy and pointers; flush and reset both empty the lane
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          head_reg  <= '0;
          tail_reg  <= '0;
          count_reg <= '0;
        end else begin
          if (do_enq) tail_reg <= tail_reg + PTR_W'(1);
          if (do_deq) head_reg <= head_reg + PTR_W'(1);
          count_reg <= count_reg + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
      end
    end
  endgenerate

  // Round-robin scan: the k-th requesting lane from rr_ptr drives CDB port k
  always_comb begin
    lane_grant  = '0;
    cdb_valid   = '0;
    cdb_rob_idx = '0;
    cdb_pd      = '0;
    cdb_rd      = '0;
    cdb_rd_v    = '0;
    cdb_lane    = '0;
    last_lane   = rr_ptr_reg;
    arb_idx     = 0;
    arb_k       = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      arb_idx = int'(rr_ptr_reg) + j;
      if (arb_idx >= NUM_FU) arb_idx = arb_idx - NUM_FU;
      if (lane_req[arb_idx] && (arb_k < NUM_CDB)) begin
        lane_grant[arb_idx] = 1'b1;
        cdb_valid[arb_k]    = 1'b1;
        cdb_rob_idx[arb_k*ROB_IDX_BITS +: ROB_IDX_BITS] =
          lane_head[arb_idx][ROB_LO +: ROB_IDX_BITS];
        cdb_pd[arb_k*PHYS_REG_BITS +: PHYS_REG_BITS] =
          lane_head[arb_idx][PD_LO +: PHYS_REG_BITS];
        cdb_rd[arb_k*ARCH_REG_BITS +: ARCH_REG_BITS] =
          lane_head[arb_idx][RD_LO +: ARCH_REG_BITS];
        cdb_rd_v[arb_k*DATA_W +: DATA_W] = lane_head[arb_idx][RD_V_LO +: DATA_W];
        cdb_lane[arb_k*LANE_W +: LANE_W] = LANE_W'(arb_idx);
        last_lane = LANE_W'(arb_idx);
        arb_k     = arb_k + 1;
      end
    end
  end

  // Next scan start is one past the last lane granted this cycle
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (|cdb_valid) begin
      rr_ptr_next = (last_lane == LANE_W'(NUM_FU - 1)) ? '0 : last_lane + LANE_W'(1);
    end
  end

  // Round-robin pointer register; held across a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (!flush) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: doc/exec_cdb_arb.md
Name: exec_cdb_arb

Overview:
- Parametrised result-collection stage between NUM_FU functional units and NUM_CDB common data bus ports.
- Each FU lane has a small in-order result FIFO with ready/valid backpressure.
- A round-robin arbiter drains up to NUM_CDB lane heads per cycle onto the CDB ports.
- Replaces fixed one-CDB-per-FU wiring. FUs may now complete at any rate without dropping tags, and CDB count is decoupled from FU count.

Parameters:
- NUM_FU, 3, number of FU input lanes (>=1)
- NUM_CDB, 1, number of CDB broadcast ports (1..NUM_FU)
- FIFO_DEPTH, 2, entries per lane FIFO (power of 2, >=2)
- ROB_IDX_BITS, 6, ROB index width
- PHYS_REG_BITS, 6, physical register tag width
- ARCH_REG_BITS, 5, architectural register index width
- DATA_W, 32, result width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; discards all buffered results
- fu_valid  in  NUM_FU  lane i presents a result
- fu_ready  out  NUM_FU  lane i FIFO can accept
- fu_rob_idx  in  NUM_FU*ROB_IDX_BITS  per-lane ROB index, lane i at slice i
- fu_pd  in  NUM_FU*PHYS_REG_BITS  per-lane physical dest
- fu_rd  in  NUM_FU*ARCH_REG_BITS  per-lane arch dest
- fu_rd_v  in  NUM_FU*DATA_W  per-lane result value
- cdb_valid  out  NUM_CDB  CDB port k carries a result this cycle
- cdb_rob_idx  out  NUM_CDB*ROB_IDX_BITS  broadcast ROB index
- cdb_pd  out  NUM_CDB*PHYS_REG_BITS  broadcast physical dest
- cdb_rd  out  NUM_CDB*ARCH_REG_BITS  broadcast arch dest
- cdb_rd_v  out  NUM_CDB*DATA_W  broadcast value
- cdb_lane  out  NUM_CDB*$clog2(NUM_FU) (min 1)  source lane of port k (debug/perf)

Behaviour:
- Reset: all FIFO counts, pointers and rr_ptr = 0. cdb_valid = 0. fu_ready = 0 while rst is high, all 1 in the first cycle after.
- fu_ready[i] = !rst && count[i] < FIFO_DEPTH. It depends only on registered count: no same-cycle dequeue credit.
- Enqueue: on the clk edge where fu_valid[i] && fu_ready[i] && !flush, {rob_idx, pd, rd, rd_v} is written at the lane tail. fu_valid with fu_ready low is ignored; the FU must hold.
- Each lane is strictly FIFO. There is no ordering guarantee across lanes.
- CDB drive (combinational from FIFO heads): scan lanes in order rr_ptr, rr_ptr+1, ... mod NUM_FU. The k-th non-empty lane found drives CDB port k for k < NUM_CDB.
  - cdb_valid[k] = 1 iff at least k+1 lanes are non-empty.
  - Unused ports drive zero fields.
- A lane driving a port is dequeued at the clk edge (unconditional; the CDB has no backpressure).
- rr_ptr update: if any port is valid, rr_ptr <= (index of last granted lane + 1) mod NUM_FU. Otherwise unchanged.
- Latency: a result enqueued at edge t appears on the CDB no earlier than the cycle after t.
- Simultaneous enqueue and dequeue on one lane: count unchanged, both pointers advance.
- Full lane: fu_ready low until a dequeue edge; it reasserts the cycle after.
- Pointers wrap modulo FIFO_DEPTH.
- flush: at that edge, all counts and pointers go to 0. rr_ptr is held. Same-cycle fu_valid is dropped.
  - cdb_valid is still driven combinationally during the flush cycle. The consumer gates it with flush.
  - cdb_valid = 0 in the following cycle.
- rst mid-operation: identical to the reset state at the next edge; buffered entries are lost.

Optional Feature:
- Macro EXEC_CDB_BYPASS_EN.
- Defined: if lane i's FIFO is empty and fu_valid[i] is high, the incoming result joins arbitration this cycle as lane i's head.
  - If granted, it appears on the CDB in the same cycle and is not written to the FIFO (zero-cycle latency).
  - If not granted, it is enqueued normally.
  - flush suppresses bypass.
- Undefined: minimum latency is one cycle as above.

Test Plan:
1. Reset, NUM_FU=3, NUM_CDB=1: assert rst 2 cycles -> cdb_valid=0 and fu_ready=000 during reset; fu_ready=111 first cycle after.
2. Lane 1 pushes {rob 5, pd 12, rd 3, v 0xDEADBEEF} at edge t -> cycle t+1: cdb_valid[0]=1, cdb_lane=1, fields match; cycle t+2 cdb_valid=0. With EXEC_CDB_BYPASS_EN it appears in cycle t and is never enqueued.
3. Fairness: all 3 lanes push every cycle, NUM_CDB=1, FIFO_DEPTH=2 -> grant sequence 0,1,2,0,1,2. Each fu_ready drops when count=2. No entry lost or duplicated; each lane's ROB indices exit in push order.
4. NUM_CDB=2, lanes 0 and 2 non-empty, rr_ptr=1 -> port0=lane2, port1=lane0, both dequeued; next rr_ptr=1.
5. Full-lane boundary: fill lane 0 to 2 entries with no drain (NUM_CDB=1, lanes 1 and 2 saturated) -> fu_ready[0]=0. An FU holding valid is accepted only after a lane-0 grant, in the following cycle.
6. Flush with lane 0 holding 2 entries and a same-cycle push -> next cycle cdb_valid=0, fu_ready=111. The pushed entry never appears on the CDB.
